// File: rtl/regfile_bypass.sv
// Architectural register file with EX/MEM/WB operand forwarding and load-use stall detection.
// Two combinational read ports, one write-back port; r0 reads as zero and is never forwarded.
module regfile_bypass #(
    parameter int REG_NUM    = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write_en_i,
    input  logic [ADDR_WIDTH-1:0] wb_reg_write_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_reg_write_data_i,
    input  logic                  ex_reg_write_en_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_write_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_reg_write_data_i,
    input  logic                  ex_is_load_i,
    input  logic                  mem_reg_write_en_i,
    input  logic [ADDR_WIDTH-1:0] mem_reg_write_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_reg_write_data_i,
    input  logic                  reg1_read_en_i,
    input  logic [ADDR_WIDTH-1:0] reg1_read_addr_i,
    input  logic                  reg2_read_en_i,
    input  logic [ADDR_WIDTH-1:0] reg2_read_addr_i,
    output logic [DATA_WIDTH-1:0] reg1_o,
    output logic [DATA_WIDTH-1:0] reg2_o,
    output logic                  stall_o
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r    [REG_NUM];
    logic                  rd_en_s   [2];
    logic [ADDR_WIDTH-1:0] rd_addr_s [2];
    logic [DATA_WIDTH-1:0] rd_data_s [2];
    logic                  load_hit_s [2];

    // Storage array: synchronous clear, write-back port with r0 writes dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wb_reg_write_en_i && (wb_reg_write_addr_i != ZERO_ADDR)) begin
            regs_r[wb_reg_write_addr_i] <= wb_reg_write_data_i;
        end
    end

    // Per-port operand resolution; youngest producer (EX) has highest priority.
    always_comb begin
        rd_en_s[0]   = reg1_read_en_i;
        rd_addr_s[0] = reg1_read_addr_i;
        rd_en_s[1]   = reg2_read_en_i;
        rd_addr_s[1] = reg2_read_addr_i;
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = ZERO_DATA;
            if (rst || !rd_en_s[p] || (rd_addr_s[p] == ZERO_ADDR)) begin
                rd_data_s[p] = ZERO_DATA;
            end else if (ex_reg_write_en_i && (ex_reg_write_addr_i == rd_addr_s[p])) begin
                rd_data_s[p] = ex_reg_write_data_i;
            end else if (mem_reg_write_en_i && (mem_reg_write_addr_i == rd_addr_s[p])) begin
                rd_data_s[p] = mem_reg_write_data_i;
            end else if (wb_reg_write_en_i && (wb_reg_write_addr_i == rd_addr_s[p])) begin
                rd_data_s[p] = wb_reg_write_data_i;
            end else begin
                rd_data_s[p] = regs_r[rd_addr_s[p]];
            end
        end
    end

    // A load still in EX cannot supply data yet; any consumer of its destination must wait.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            load_hit_s[p] = rd_en_s[p] && (rd_addr_s[p] == ex_reg_write_addr_i);
        end
        if (!rst && ex_is_load_i && ex_reg_write_en_i && (ex_reg_write_addr_i != ZERO_ADDR)) begin
            stall_o = load_hit_s[0] || load_hit_s[1];
        end else begin
            stall_o = 1'b0;
        end
    end

    assign reg1_o = rd_data_s[0];
    assign reg2_o = rd_data_s[1];

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: a spec-level model checked every cycle plus literal expectations.
module tb_regfile_bypass;

    logic        clk;
    logic        rst;
    logic        wb_en, ex_en, mem_en, ex_load, r1_en, r2_en;
    logic [4:0]  wb_addr, ex_addr, mem_addr, r1_addr, r2_addr;
    logic [31:0] wb_data, ex_data, mem_data;
    logic [31:0] reg1, reg2;
    logic        stall;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] model_regs [32];

    regfile_bypass #(.REG_NUM(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_write_en_i(wb_en), .wb_reg_write_addr_i(wb_addr), .wb_reg_write_data_i(wb_data),
        .ex_reg_write_en_i(ex_en), .ex_reg_write_addr_i(ex_addr), .ex_reg_write_data_i(ex_data),
        .ex_is_load_i(ex_load),
        .mem_reg_write_en_i(mem_en), .mem_reg_write_addr_i(mem_addr), .mem_reg_write_data_i(mem_data),
        .reg1_read_en_i(r1_en), .reg1_read_addr_i(r1_addr),
        .reg2_read_en_i(r2_en), .reg2_read_addr_i(r2_addr),
        .reg1_o(reg1), .reg2_o(reg2), .stall_o(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural state as the spec describes it: cleared by reset, WB writes except r0.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'h0;
        end else if (wb_en && wb_addr != 5'd0) begin
            model_regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'h0;
        if (ex_en && ex_addr == a) return ex_data;
        if (mem_en && mem_addr == a) return mem_data;
        if (wb_en && wb_addr == a) return wb_data;
        return model_regs[a];
    endfunction

    function automatic logic exp_stall();
        if (rst || !ex_load || !ex_en || ex_addr == 5'd0) return 1'b0;
        return (r1_en && r1_addr == ex_addr) || (r2_en && r2_addr == ex_addr);
    endfunction

    // Model comparison once per cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_reg1", reg1, exp_read(r1_en, r1_addr));
        check("model_reg2", reg2, exp_read(r2_en, r2_addr));
        check("model_stall", {31'd0, stall}, {31'd0, exp_stall()});
    end

    task automatic idle();
        wb_en = 1'b0; ex_en = 1'b0; mem_en = 1'b0; ex_load = 1'b0; r1_en = 1'b0; r2_en = 1'b0;
        wb_addr = 5'd0; ex_addr = 5'd0; mem_addr = 5'd0; r1_addr = 5'd0; r2_addr = 5'd0;
        wb_data = 32'h0; ex_data = 32'h0; mem_data = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // Test 1: reset with a coincident WB write to r5
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        r1_en = 1'b1; r1_addr = 5'd5;
        @(negedge clk);
        check("rst_reg1", reg1, 32'h0);
        check("rst_stall", {31'd0, stall}, 32'h0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        rst = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        check("post_rst_r5", reg1, 32'h0);
        check("post_rst_stall", {31'd0, stall}, 32'h0);

        // Test 2: write-through then stored read
        next_cycle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234_5678; r1_addr = 5'd3;
        @(negedge clk);
        check("wt_r3", reg1, 32'h1234_5678);
        next_cycle();
        wb_en = 1'b0;
        @(negedge clk);
        check("stored_r3", reg1, 32'h1234_5678);

        // Test 3: r0 immutability, including an EX load targeting r0
        next_cycle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        ex_en = 1'b1; ex_addr = 5'd0; ex_data = 32'h0000_0001; ex_load = 1'b1;
        mem_en = 1'b1; mem_addr = 5'd0; mem_data = 32'h0000_0002;
        r1_addr = 5'd0; r2_en = 1'b1; r2_addr = 5'd0;
        @(negedge clk);
        check("r0_reg1", reg1, 32'h0);
        check("r0_reg2", reg2, 32'h0);
        check("r0_stall", {31'd0, stall}, 32'h0);
        next_cycle();
        idle();
        r1_en = 1'b1; r1_addr = 5'd0;
        @(negedge clk);
        check("r0_after_write", reg1, 32'h0);

        // Test 4: forwarding priority on r7 with array value 0x11
        next_cycle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0011;
        next_cycle();
        ex_en = 1'b1; ex_addr = 5'd7; ex_data = 32'hAAAA_0001;
        mem_en = 1'b1; mem_addr = 5'd7; mem_data = 32'hBBBB_0002;
        wb_addr = 5'd7; wb_data = 32'hCCCC_0003;
        r2_en = 1'b1; r2_addr = 5'd7;
        @(negedge clk);
        check("prio_ex", reg2, 32'hAAAA_0001);
        ex_en = 1'b0; #1;
        check("prio_mem", reg2, 32'hBBBB_0002);
        mem_en = 1'b0; #1;
        check("prio_wb", reg2, 32'hCCCC_0003);
        wb_en = 1'b0; #1;
        check("prio_array", reg2, 32'h0000_0011);

        // Test 5: load-use stall
        next_cycle();
        idle();
        ex_en = 1'b1; ex_load = 1'b1; ex_addr = 5'd9; ex_data = 32'h0BAD_0BAD;
        r2_en = 1'b1; r2_addr = 5'd9;
        @(negedge clk);
        check("lu_stall", {31'd0, stall}, 32'h1);
        r2_en = 1'b0; #1;
        check("lu_no_en", {31'd0, stall}, 32'h0);
        r1_en = 1'b1; r1_addr = 5'd9; #1;
        check("lu_stall_p1", {31'd0, stall}, 32'h1);
        next_cycle();
        idle();
        mem_en = 1'b1; mem_addr = 5'd9; mem_data = 32'h0000_0055;
        r2_en = 1'b1; r2_addr = 5'd9;
        @(negedge clk);
        check("lu_mem_stall", {31'd0, stall}, 32'h0);
        check("lu_mem_data", reg2, 32'h0000_0055);

        // Test 6: dual-port independence
        next_cycle();
        idle();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
        next_cycle();
        wb_en = 1'b0;
        mem_en = 1'b1; mem_addr = 5'd6; mem_data = 32'h0000_0066;
        r1_en = 1'b1; r1_addr = 5'd4; r2_en = 1'b1; r2_addr = 5'd6;
        @(negedge clk);
        check("dual_r4", reg1, 32'h0000_0044);
        check("dual_r6", reg2, 32'h0000_0066);
        next_cycle();
        r2_addr = 5'd4;
        @(negedge clk);
        check("same_p1", reg1, 32'h0000_0044);
        check("same_p2", reg2, 32'h0000_0044);

        // Mixed traffic, checked by the model every cycle
        for (int i = 1; i < 40; i++) begin
            next_cycle();
            wb_en = (i % 3) != 0;        wb_addr = 5'(i * 7);  wb_data = 32'h1000_0000 + 32'(i);
            ex_en = (i % 4) == 1;        ex_addr = 5'(i * 3);  ex_data = 32'h2000_0000 + 32'(i);
            ex_load = (i % 5) < 2;
            mem_en = (i % 2) == 0;       mem_addr = 5'(i * 5); mem_data = 32'h3000_0000 + 32'(i);
            r1_en = (i % 7) != 0;        r1_addr = 5'(i * 3);
            r2_en = (i % 6) != 0;        r2_addr = 5'(i * 5 + 1);
        end

        // Reset mid-operation loses the coincident write and clears stored values
        next_cycle();
        idle();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h7777_7777;
        next_cycle();
        rst = 1'b0; wb_en = 1'b0; r1_en = 1'b1; r1_addr = 5'd3;
        @(negedge clk);
        check("midrst_r3", reg1, 32'h0);

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Architectural general-purpose register file for the scalar pipeline, with operand forwarding.
- Consumes the write-back triple (write enable, write address, write data) that the execute path produces and carries down the pipe.
- Supplies the two source operands (reg1/reg2) to decode/issue. Operand sources are forwarded EX and MEM results, a same-cycle WB write, or the storage array.
- Detects load-use hazards and raises a stall request.

Parameters:
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.
- ADDR_WIDTH, 5, register address width; must satisfy 2^ADDR_WIDTH = REG_NUM.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_reg_write_en_i  in  1  write-back write enable.
- wb_reg_write_addr_i  in  ADDR_WIDTH  write-back destination register.
- wb_reg_write_data_i  in  DATA_WIDTH  write-back data.
- ex_reg_write_en_i  in  1  EX-stage result will write a register.
- ex_reg_write_addr_i  in  ADDR_WIDTH  EX-stage destination register.
- ex_reg_write_data_i  in  DATA_WIDTH  EX-stage ALU result.
- ex_is_load_i  in  1  EX-stage instruction is a load; its data is not yet valid.
- mem_reg_write_en_i  in  1  MEM-stage write enable.
- mem_reg_write_addr_i  in  ADDR_WIDTH  MEM-stage destination register.
- mem_reg_write_data_i  in  DATA_WIDTH  MEM-stage result.
- reg1_read_en_i  in  1  operand 1 is required.
- reg1_read_addr_i  in  ADDR_WIDTH  operand 1 source register.
- reg2_read_en_i  in  1  operand 2 is required.
- reg2_read_addr_i  in  ADDR_WIDTH  operand 2 source register.
- reg1_o  out  DATA_WIDTH  operand 1 value.
- reg2_o  out  DATA_WIDTH  operand 2 value.
- stall_o  out  1  load-use stall request to the front end.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst is sampled on the rising edge of clk. On that edge, every array entry clears to 0 and any WB write in the same cycle is discarded.
- Storage write:
  - On the rising edge of clk with rst=0, wb_reg_write_en_i=1 and wb_reg_write_addr_i!=0, the array entry at the WB address takes wb_reg_write_data_i.
  - Writes to r0 are dropped; entry 0 is never stored as nonzero.
- Reads:
  - Combinational; zero-cycle latency from address/enable to reg1_o/reg2_o.
  - Each port resolves independently using identical rules.
- Read priority, per port, first match wins:
  1. rst=1 -> 0.
  2. read_en=0 -> 0.
  3. read_addr=0 -> 0. No forwarding ever applies to r0.
  4. ex_reg_write_en_i=1 and ex_reg_write_addr_i==read_addr -> ex_reg_write_data_i. This applies even when ex_is_load_i=1; the value is don't-care because stall_o is asserted.
  5. mem_reg_write_en_i=1 and mem address match -> mem_reg_write_data_i.
  6. wb_reg_write_en_i=1 and wb address match -> wb_reg_write_data_i (same-cycle write-through).
  7. Otherwise -> array entry.
- Youngest producer wins: EX beats MEM beats WB when addresses collide.
- Both ports reading the same register return identical values.
- Load-use stall:
  - stall_o=1 iff rst=0, ex_is_load_i=1, ex_reg_write_en_i=1, ex_reg_write_addr_i!=0, and for some port p, reg_p_read_en_i=1 and reg_p_read_addr_i==ex_reg_write_addr_i.
  - Otherwise stall_o=0.
  - Combinational. The front end holds decode and inserts a bubble into EX; this block holds no stall state.
  - A load in MEM never stalls; its data is forwarded from mem_reg_write_data_i.
- Reset values: reg1_o=0, reg2_o=0, stall_o=0 while rst=1; all array entries 0 after the reset edge.
- Reset mid-operation: a WB write coincident with the reset edge is lost. The first read after rst deasserts returns 0 for every unforwarded register.
- No X propagation: all outputs are defined for every input combination.

Test Plan:
1. Reset then read: assert rst for 2 cycles with WB writing r5=0xDEAD_BEEF in the same cycles -> after rst drops, reading r5 with no forwarding gives reg1_o=0; stall_o=0 throughout.
2. Write then read: WB writes r3=0x1234_5678 at edge N -> at cycle N+1, reg1 read of r3 gives 0x1234_5678. Reading r3 in cycle N itself gives 0x1234_5678 via the write-through path.
3. r0 immutability: WB writes r0=0xFFFF_FFFF; EX and MEM also target r0 with nonzero data -> reg1_o=reg2_o=0 when reading r0; stall_o=0 even with ex_is_load_i=1.
4. Forward priority: EX r7=0xAAAA_0001, MEM r7=0xBBBB_0002, WB r7=0xCCCC_0003, array r7=0x11 -> reg2_o=0xAAAA_0001. Drop EX enable -> 0xBBBB_0002. Drop MEM -> 0xCCCC_0003. Drop WB -> 0x11.
5. Load-use stall:
   - ex_is_load_i=1 writing r9, reg2 reads r9 with en=1 -> stall_o=1.
   - Same with reg2_read_en_i=0 -> stall_o=0.
   - Load moved to MEM with data 0x55 -> stall_o=0 and reg2_o=0x55.
6. Dual-port independence: reg1 reads r4 (array 0x44), reg2 reads r6 forwarded from MEM 0x66 -> reg1_o=0x44, reg2_o=0x66. Reading r4 on both ports -> both 0x44.
